lrf_multiport: RTL and testbench
================================

Name: lrf_multiport

Overview:
- Parametrised architectural (logic) register file for the out-of-order MIPS core, read by dispatch for a non-data-capture issue queue and written by the commit stage.
- Holds GPR r1..r31 plus HI and LO in a single 6-bit address space.
- Read-port count, write-port count, data width, optional same-cycle write-to-read bypass, and optional registered read output are all configurable.
- Adds HI/LO writes through the normal write ports and a registered write-conflict flag.

Parameters:
- DW, 32, data width of every register.
- NR, 4, number of read ports (1..8).
- NW, 2, number of write ports (1..4); higher port index has priority.
- BYPASS, 1, 1 = a read of an address written this cycle returns the winning write data; 0 = returns the stored value.
- READ_REG, 0, 0 = combinational read; 1 = read data registered, one-cycle latency.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- rd_addr  in  NR*6  read addresses; port i uses bits [6i+5:6i].
- rd_data  out  NR*DW  read data; port i uses bits [DW*i+DW-1:DW*i].
- wen  in  NW  write enable per port.
- wr_addr  in  NW*6  write addresses, packed like rd_addr.
- wr_data  in  NW*DW  write data, packed like rd_data.
- hi_q  out  DW  current HI value (debug and difftest).
- lo_q  out  DW  current LO value.
- wr_conflict  out  1  registered flag: previous cycle had two or more enabled writes to the same writable address.

Behaviour:
- Address map:
  - addr[5]=0 selects GPR addr[4:0].
  - addr[5]=1 with addr[0]=1 selects HI; addr[5]=1 with addr[0]=0 selects LO. addr[4:1] are ignored.
  - r0 always reads 0, and writes to r0 are discarded.
- Reset: asynchronous clear of all GPRs, HI, LO and wr_conflict to 0. When READ_REG=1, rd_data registers also clear to 0. On reset release, all reads return 0.
- Write, at the clock edge:
  - Each enabled port updates its target.
  - When several enabled ports target the same register, the highest-index port's data is stored; lower ports to that address have no effect.
  - Disabled ports never write, whatever their addr/data.
- Read with READ_REG=0:
  - rd_data is combinational from the current state.
  - With BYPASS=1, if any enabled write port targets the same register (not r0), the output is the highest-priority matching wr_data; otherwise the stored value.
  - With BYPASS=0, the output is the stored value.
- Read with READ_REG=1:
  - rd_data at edge t+1 equals the value computed at edge t from rd_addr(t). That value is the BYPASS-resolved result when BYPASS=1, else the stored value.
  - Net effect with BYPASS=1: the output equals the register contents immediately after the edge-t writes.
- hi_q and lo_q show stored values only, never bypassed; they update one edge after the write.
- wr_conflict:
  - Set at an edge when two or more enabled write ports target the same register other than r0. HI and LO count as distinct registers.
  - Cleared at any edge without such a collision. It is a single-cycle pulse per colliding cycle.
- Reset asserted mid-operation: all state clears immediately, including in-flight READ_REG outputs. Writes presented while reset is high are lost.
- All read ports are independent. Any number of ports may read the same address in the same cycle.

Test Plan:
- Reset, then read all 34 addresses on every port -> all 0. wr_conflict=0.
- NW=2: wen=2'b11, port0 writes r5=0x1111_1111 and port1 writes r5=0x2222_2222; next cycle read r5 -> 0x2222_2222 and wr_conflict=1. Following idle cycle -> wr_conflict=0.
- BYPASS=1, READ_REG=0: write r7=0xDEAD_BEEF and read r7 in the same cycle -> rd_data=0xDEAD_BEEF before the edge. With BYPASS=0 -> old value 0.
- Port0 writes addr 6'h21 (HI)=0xAAAA_0001 and port1 writes 6'h20 (LO)=0x5555_0002 -> hi_q/lo_q update next cycle. Reads of 6'h33/6'h22 return HI/LO. wr_conflict=0.
- Write r0=0xFFFF_FFFF on both ports -> r0 reads 0 and wr_conflict=0.
- READ_REG=1, BYPASS=1: write r3=0x0000_00AB at edge t while reading r3 -> rd_data=0xAB after edge t. Assert reset between edges -> rd_data drops to 0 immediately.

Source files
------------

// File: rtl/lrf_multiport.sv
// Architectural register file: GPR r1..r31 plus HI/LO in one 6-bit address space.
// Prioritised multi-port writes, optional write-to-read bypass and an optional registered read stage.
module lrf_multiport #(
  parameter int DW       = 32,
  parameter int NR       = 4,
  parameter int NW       = 2,
  parameter int BYPASS   = 1,
  parameter int READ_REG = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NR*6-1:0]  rd_addr,
  output logic [NR*DW-1:0] rd_data,
  input  logic [NW-1:0]    wen,
  input  logic [NW*6-1:0]  wr_addr,
  input  logic [NW*DW-1:0] wr_data,
  output logic [DW-1:0]    hi_q,
  output logic [DW-1:0]    lo_q,
  output logic             wr_conflict
);

  // HI and LO alias across addr[4:1]; fold them to 6'h21 / 6'h20 so compares are exact
  function automatic logic [5:0] canon(input logic [5:0] a);
    canon = a[5] ? {5'b10000, a[0]} : a;
  endfunction

  logic [DW-1:0] gpr [32];
  logic [DW-1:0] hi_r;
  logic [DW-1:0] lo_r;
  logic [5:0]    wr_c [NW];
  logic [5:0]    rd_c [NR];
  logic [DW-1:0] rd_val [NR];
  logic          conflict_now;

  always_comb begin
    for (int j = 0; j < NW; j++) begin
      wr_c[j] = canon(wr_addr[6*j +: 6]);
    end
  end

  always_comb begin
    conflict_now = 1'b0;
    for (int i = 0; i < NW; i++) begin
      for (int j = i + 1; j < NW; j++) begin
        if (wen[i] && wen[j] && (wr_c[i] == wr_c[j]) && (wr_c[i] != 6'd0)) begin
          conflict_now = 1'b1;
        end
      end
    end
  end

  // Ascending port loop: the last non-blocking update wins, giving the highest port priority
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 32; k++) begin
        gpr[k] <= '0;
      end
      hi_r        <= '0;
      lo_r        <= '0;
      wr_conflict <= 1'b0;
    end else begin
      for (int j = 0; j < NW; j++) begin
        if (wen[j]) begin
          if (!wr_c[j][5]) begin
            if (wr_c[j][4:0] != 5'd0) begin
              gpr[wr_c[j][4:0]] <= wr_data[DW*j +: DW];
            end
          end else if (wr_c[j][0]) begin
            hi_r <= wr_data[DW*j +: DW];
          end else begin
            lo_r <= wr_data[DW*j +: DW];
          end
        end
      end
      wr_conflict <= conflict_now;
    end
  end

  // gpr[0] is never written, so r0 reads as zero without a special case
  always_comb begin
    for (int i = 0; i < NR; i++) begin
      rd_c[i]   = canon(rd_addr[6*i +: 6]);
      rd_val[i] = rd_c[i][5] ? (rd_c[i][0] ? hi_r : lo_r) : gpr[rd_c[i][4:0]];
      if (BYPASS != 0) begin
        for (int j = 0; j < NW; j++) begin
          if (wen[j] && (wr_c[j] == rd_c[i]) && (rd_c[i] != 6'd0)) begin
            rd_val[i] = wr_data[DW*j +: DW];
          end
        end
      end
    end
  end

  assign hi_q = hi_r;
  assign lo_q = lo_r;

  generate
    if (READ_REG != 0) begin : g_rd_reg
      logic [DW-1:0] rd_q [NR];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < NR; i++) begin
            rd_q[i] <= '0;
          end
        end else begin
          for (int i = 0; i < NR; i++) begin
            rd_q[i] <= rd_val[i];
          end
        end
      end

      for (genvar i = 0; i < NR; i++) begin : g_out
        assign rd_data[DW*i +: DW] = rd_q[i];
      end
    end else begin : g_rd_comb
      for (genvar i = 0; i < NR; i++) begin : g_out
        assign rd_data[DW*i +: DW] = rd_val[i];
      end
    end
  endgenerate

endmodule

// File: tb/tb_lrf_multiport.sv
// Directed bench for lrf_multiport: three instances (bypass comb, no-bypass comb, registered bypass)
// share one stimulus stream; vectors carry hand-computed expectations.
module tb_lrf_multiport;

  logic         clk;
  logic         reset;
  logic [23:0]  rd_addr;
  logic [1:0]   wen;
  logic [11:0]  wr_addr;
  logic [63:0]  wr_data;

  logic [127:0] rd_byp, rd_nb, rd_rr;
  logic [31:0]  hi_byp, lo_byp, hi_nb, lo_nb, hi_rr, lo_rr;
  logic         conf_byp, conf_nb, conf_rr;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic [1:0]   wen;
    logic [11:0]  wa;
    logic [63:0]  wd;
    logic [23:0]  ra;
    logic [127:0] exp_byp;
    logic [127:0] exp_nb;
    logic         conf;
    logic [31:0]  hi;
    logic [31:0]  lo;
  } vec_t;

  vec_t vecs [8];

  lrf_multiport #(.DW(32), .NR(4), .NW(2), .BYPASS(1), .READ_REG(0)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_byp), .wen(wen),
    .wr_addr(wr_addr), .wr_data(wr_data), .hi_q(hi_byp), .lo_q(lo_byp), .wr_conflict(conf_byp));

  lrf_multiport #(.DW(32), .NR(4), .NW(2), .BYPASS(0), .READ_REG(0)) dut_nb (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_nb), .wen(wen),
    .wr_addr(wr_addr), .wr_data(wr_data), .hi_q(hi_nb), .lo_q(lo_nb), .wr_conflict(conf_nb));

  lrf_multiport #(.DW(32), .NR(4), .NW(2), .BYPASS(1), .READ_REG(1)) dut_rr (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_rr), .wen(wen),
    .wr_addr(wr_addr), .wr_data(wr_data), .hi_q(hi_rr), .lo_q(lo_rr), .wr_conflict(conf_rr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] w, input logic [11:0] wa,
                                input logic [63:0] wd, input logic [23:0] ra);
    wen     = w;
    wr_addr = wa;
    wr_data = wd;
    rd_addr = ra;
  endtask

  initial begin
    logic [5:0] a;
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    apply_stimulus(2'b00, 12'h0, 64'h0, 24'h0);

    vecs[0] = '{2'b11, {6'd5, 6'd5}, {32'h2222_2222, 32'h1111_1111}, {6'h20, 6'h21, 6'd0, 6'd5},
                {32'h0, 32'h0, 32'h0, 32'h2222_2222}, 128'h0, 1'b1, 32'h0, 32'h0};
    vecs[1] = '{2'b00, {6'd0, 6'd0}, 64'h0, {6'd0, 6'd0, 6'd0, 6'd5},
                {32'h0, 32'h0, 32'h0, 32'h2222_2222}, {32'h0, 32'h0, 32'h0, 32'h2222_2222},
                1'b0, 32'h0, 32'h0};
    vecs[2] = '{2'b01, {6'd7, 6'd7}, {32'h1234_5678, 32'hDEAD_BEEF}, {6'd0, 6'd7, 6'd5, 6'd7},
                {32'h0, 32'hDEAD_BEEF, 32'h2222_2222, 32'hDEAD_BEEF},
                {32'h0, 32'h0, 32'h2222_2222, 32'h0}, 1'b0, 32'h0, 32'h0};
    vecs[3] = '{2'b11, {6'h20, 6'h21}, {32'h5555_0002, 32'hAAAA_0001}, {6'h3F, 6'd7, 6'h22, 6'h33},
                {32'hAAAA_0001, 32'hDEAD_BEEF, 32'h5555_0002, 32'hAAAA_0001},
                {32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0}, 1'b0, 32'hAAAA_0001, 32'h5555_0002};
    vecs[4] = '{2'b11, {6'd0, 6'd0}, {32'hFFFF_FFFF, 32'hFFFF_FFFF}, {6'd5, 6'h20, 6'h21, 6'd0},
                {32'h2222_2222, 32'h5555_0002, 32'hAAAA_0001, 32'h0},
                {32'h2222_2222, 32'h5555_0002, 32'hAAAA_0001, 32'h0},
                1'b0, 32'hAAAA_0001, 32'h5555_0002};
    vecs[5] = '{2'b11, {6'h3D, 6'h23}, {32'h2, 32'h1}, {6'd7, 6'd0, 6'h20, 6'h21},
                {32'hDEAD_BEEF, 32'h0, 32'h5555_0002, 32'h2},
                {32'hDEAD_BEEF, 32'h0, 32'h5555_0002, 32'hAAAA_0001},
                1'b1, 32'h2, 32'h5555_0002};
    vecs[6] = '{2'b10, {6'd9, 6'd9}, {32'h0000_BBBB, 32'h0000_AAAA}, {6'd9, 6'd9, 6'd9, 6'd9},
                {32'hBBBB, 32'hBBBB, 32'hBBBB, 32'hBBBB}, 128'h0, 1'b0, 32'h2, 32'h5555_0002};
    vecs[7] = '{2'b11, {6'd30, 6'd31}, {32'h22, 32'h11}, {6'd1, 6'd9, 6'd30, 6'd31},
                {32'h0, 32'hBBBB, 32'h22, 32'h11}, {32'h0, 32'hBBBB, 32'h0, 32'h0},
                1'b0, 32'h2, 32'h5555_0002};

    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Every address on every port must read zero after reset
    for (int k = 0; k < 34; k++) begin
      @(negedge clk);
      a = (k < 32) ? 6'(k) : ((k == 32) ? 6'h20 : 6'h21);
      apply_stimulus(2'b00, 12'h0, 64'h0, {a, a, a, a});
      #2;
      check_output($sformatf("reset_rd_byp_a%0h", a), rd_byp, 128'h0);
      check_output($sformatf("reset_rd_nb_a%0h", a), rd_nb, 128'h0);
      @(posedge clk);
      #1;
      check_output($sformatf("reset_rd_rr_a%0h", a), rd_rr, 128'h0);
    end
    check_output("reset_conflict", {127'h0, conf_byp}, 128'h0);
    check_output("reset_hi", {96'h0, hi_byp}, 128'h0);
    check_output("reset_lo", {96'h0, lo_byp}, 128'h0);

    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      apply_stimulus(vecs[v].wen, vecs[v].wa, vecs[v].wd, vecs[v].ra);
      #2;
      check_output($sformatf("v%0d_rd_byp", v), rd_byp, vecs[v].exp_byp);
      check_output($sformatf("v%0d_rd_nb", v), rd_nb, vecs[v].exp_nb);
      @(posedge clk);
      #1;
      check_output($sformatf("v%0d_rd_rr", v), rd_rr, vecs[v].exp_byp);
      check_output($sformatf("v%0d_conflict", v), {127'h0, conf_byp}, {127'h0, vecs[v].conf});
      check_output($sformatf("v%0d_conflict_rr", v), {127'h0, conf_rr}, {127'h0, vecs[v].conf});
      check_output($sformatf("v%0d_hi", v), {96'h0, hi_byp}, {96'h0, vecs[v].hi});
      check_output($sformatf("v%0d_lo", v), {96'h0, lo_byp}, {96'h0, vecs[v].lo});
    end

    // Registered read: one-cycle latency, then async reset must clear it between edges
    @(negedge clk);
    apply_stimulus(2'b00, 12'h0, 64'h0, {6'd3, 6'd3, 6'd3, 6'd3});
    @(posedge clk);
    #1;
    check_output("rr_idle_r3", rd_rr, 128'h0);
    @(negedge clk);
    apply_stimulus(2'b01, {6'd0, 6'd3}, {32'h0, 32'h0000_00AB}, {6'd3, 6'd3, 6'd3, 6'd3});
    #2;
    check_output("rr_pre_edge_r3", rd_rr, 128'h0);
    check_output("byp_r3_same_cycle", rd_byp, {4{32'h0000_00AB}});
    @(posedge clk);
    #1;
    check_output("rr_post_edge_r3", rd_rr, {4{32'h0000_00AB}});
    apply_stimulus(2'b00, 12'h0, 64'h0, {6'd3, 6'd3, 6'd3, 6'd3});
    #2;
    reset = 1'b1;
    #1;
    check_output("rr_async_reset", rd_rr, 128'h0);
    check_output("byp_async_reset_r3", rd_byp, 128'h0);
    check_output("hi_async_reset", {96'h0, hi_byp}, 128'h0);

    // Writes presented while reset is held are lost
    @(negedge clk);
    apply_stimulus(2'b11, {6'd4, 6'd4}, {32'h77, 32'h66}, {6'd4, 6'd4, 6'd4, 6'd4});
    @(posedge clk);
    @(negedge clk);
    apply_stimulus(2'b00, 12'h0, 64'h0, {6'd4, 6'd4, 6'd4, 6'd4});
    reset = 1'b0;
    #2;
    check_output("write_during_reset_lost", rd_byp, 128'h0);
    check_output("conflict_during_reset", {127'h0, conf_byp}, 128'h0);
    @(posedge clk);
    #1;
    check_output("rr_after_reset_r4", rd_rr, 128'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
